// File: rtl/exu_mc_if.sv
// Handshake bundle between an issuing stage and the multi-cycle execution unit.
// master issues operations and consumes results; slave is the execution unit.
interface exu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/exu_mc.sv
// Execution unit: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Latency 1 cycle for ALU/bypassed divides, XLEN+1 for MUL/DIV; result held in DONE until out_ready.
module exu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic        clk,
    input logic        rst,
    exu_mc_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef logic [SHW:0] cnt_t;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_AND    = 5'd2,  OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_SLT  = 5'd5,  OP_SLTU   = 5'd6,  OP_SLL   = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA  = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;
    localparam cnt_t       CNT_LAST = cnt_t'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state, w_next;
    cnt_t              r_cnt;
    logic [4:0]        r_op;
    logic [XLEN-1:0]   r_opa;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_q, r_neg_r;
    logic [XLEN-1:0]   r_result;

    logic              w_accept, w_is_mul, w_is_div, w_div_signed, w_src2_zero, w_ovf, w_bypass;
    logic              w_s1, w_s2;
    logic [XLEN-1:0]   w_abs1, w_abs2, w_alu;
    logic [XLEN-1:0]   w_setup_opa, w_setup_lo;
    logic              w_setup_negq, w_setup_negr;
    logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_mul_step, w_div_step, w_prod;
    logic              w_qbit;
    logic [XLEN-1:0]   w_quo, w_rem, w_mul_res, w_div_res;

    assign bus.in_ready  = (r_state == S_IDLE) & ~bus.flush & ~rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = r_result;

    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_is_mul     = (bus.op >= OP_MUL) && (bus.op <= OP_MULHU);
    assign w_is_div     = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
    assign w_div_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign w_src2_zero  = (bus.src2 == '0);
    assign w_ovf        = w_div_signed && (bus.src1 == MOST_NEG) && (bus.src2 == '1);
    assign w_bypass     = w_is_div & (w_src2_zero | w_ovf);

    assign w_s1   = bus.src1[XLEN-1];
    assign w_s2   = bus.src2[XLEN-1];
    assign w_abs1 = w_s1 ? -bus.src1 : bus.src1;
    assign w_abs2 = w_s2 ? -bus.src2 : bus.src2;

    // Single-cycle results, including the divide-by-zero and overflow shortcuts.
    always_comb begin
        w_alu = '0;
        case (bus.op)
            OP_ADD:  w_alu = bus.src1 + bus.src2;
            OP_SUB:  w_alu = bus.src1 - bus.src2;
            OP_AND:  w_alu = bus.src1 & bus.src2;
            OP_OR:   w_alu = bus.src1 | bus.src2;
            OP_XOR:  w_alu = bus.src1 ^ bus.src2;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(bus.src1) < $signed(bus.src2)};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, bus.src1 < bus.src2};
            OP_SLL:  w_alu = bus.src1 << bus.src2[SHW-1:0];
            OP_SRL:  w_alu = bus.src1 >> bus.src2[SHW-1:0];
            OP_SRA:  w_alu = $signed(bus.src1) >>> bus.src2[SHW-1:0];
            OP_DIV, OP_DIVU: w_alu = w_src2_zero ? '1 : MOST_NEG;
            OP_REM, OP_REMU: w_alu = w_src2_zero ? bus.src1 : '0;
            default: w_alu = '0;
        endcase
    end

    // Iterative units run on magnitudes; sign flags are applied when the last step retires.
    always_comb begin
        w_setup_opa  = bus.src1;
        w_setup_lo   = bus.src2;
        w_setup_negq = 1'b0;
        w_setup_negr = 1'b0;
        case (bus.op)
            OP_MULH: begin
                w_setup_opa  = w_abs1;
                w_setup_lo   = w_abs2;
                w_setup_negq = w_s1 ^ w_s2;
            end
            OP_MULHSU: begin
                w_setup_opa  = w_abs1;
                w_setup_negq = w_s1;
            end
            OP_DIV, OP_REM: begin
                w_setup_opa  = w_abs2;
                w_setup_lo   = w_abs1;
                w_setup_negq = w_s1 ^ w_s2;
                w_setup_negr = w_s1;
            end
            OP_DIVU, OP_REMU: begin
                w_setup_opa = bus.src2;
                w_setup_lo  = bus.src1;
            end
            default: ;
        endcase
    end

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod     = r_neg_q ? -w_mul_step : w_mul_step;
    assign w_mul_res  = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opa};
    assign w_qbit     = ~w_diff[XLEN];
    assign w_div_step = {w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], w_qbit};
    assign w_quo      = r_neg_q ? -w_div_step[XLEN-1:0] : w_div_step[XLEN-1:0];
    assign w_rem      = r_neg_r ? -w_div_step[2*XLEN-1:XLEN] : w_div_step[2*XLEN-1:XLEN];
    assign w_div_res  = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? w_quo : w_rem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_is_mul)                   w_next = S_MUL;
                else if (w_is_div && !w_bypass) w_next = S_DIV;
                else                            w_next = S_DONE;
            end
            S_MUL, S_DIV: if (r_cnt == CNT_LAST) w_next = S_DONE;
            S_DONE:       if (bus.out_ready)     w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_opa    <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt    <= '0;
                    r_op     <= bus.op;
                    r_opa    <= w_setup_opa;
                    r_acc    <= {{XLEN{1'b0}}, w_setup_lo};
                    r_neg_q  <= w_setup_negq;
                    r_neg_r  <= w_setup_negr;
                    r_result <= w_alu;
                end
                S_MUL: begin
                    r_acc <= w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_result <= w_mul_res;
                end
                S_DIV: begin
                    r_acc <= w_div_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_result <= w_div_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_mc.sv
// Directed-vector bench for exu_mc: result and latency table plus backpressure, flush and reset sequences.
module tb_exu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exu_mc_if #(.XLEN(32)) bus ();
    exu_mc #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op; returns edges after accept until out_valid (0 = valid right after accept).
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit accepted);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.src1 = a;
        bus.src2 = b;
        #1 accepted = bus.in_ready;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 5'd1;
        bus.src1 = ~a;
        bus.src2 = 32'h5;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        res = bus.result;
    endtask

    task automatic retire(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({name, " drop"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    endtask

    int          lat;
    logic [31:0] res;
    bit          acc;
    bit          seen;
    bit          stable;

    initial begin
        bus.in_valid = 0; bus.op = 0; bus.src1 = 0; bus.src2 = 0;
        bus.flush = 0; bus.out_ready = 0;

        vq.push_back('{"add",      5'd0,  32'd5,        32'd7,        32'd12,       0});
        vq.push_back('{"sub",      5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 0});
        vq.push_back('{"and",      5'd2,  32'hF0F0,     32'hFF00,     32'hF000,     0});
        vq.push_back('{"or",       5'd3,  32'hF0F0,     32'hFF00,     32'hFFF0,     0});
        vq.push_back('{"xor",      5'd4,  32'hF0F0,     32'hFF00,     32'h0FF0,     0});
        vq.push_back('{"slt",      5'd5,  32'hFFFFFFFF, 32'd1,        32'd1,        0});
        vq.push_back('{"sltu",     5'd6,  32'hFFFFFFFF, 32'd1,        32'd0,        0});
        vq.push_back('{"sll",      5'd7,  32'd1,        32'h21,       32'd2,        0});
        vq.push_back('{"srl",      5'd8,  32'h80000000, 32'd4,        32'h08000000, 0});
        vq.push_back('{"sra",      5'd9,  32'h80000000, 32'h24,       32'hF8000000, 0});
        vq.push_back('{"op20",     5'd20, 32'd5,        32'd7,        32'd0,        0});
        vq.push_back('{"mul",      5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32});
        vq.push_back('{"mulh",     5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32});
        vq.push_back('{"mulhsu",   5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32});
        vq.push_back('{"mulhu",    5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32});
        vq.push_back('{"mul2",     5'd10, 32'd1234,     32'd5678,     32'h006AE9BC, 32});
        vq.push_back('{"div",      5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32});
        vq.push_back('{"rem",      5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32});
        vq.push_back('{"div_pn",   5'd14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32});
        vq.push_back('{"rem_pn",   5'd16, 32'd7,        32'hFFFFFFFE, 32'd1,        32});
        vq.push_back('{"divu",     5'd15, 32'd100,      32'd7,        32'd14,       32});
        vq.push_back('{"remu",     5'd17, 32'd100,      32'd7,        32'd2,        32});
        vq.push_back('{"divu_big", 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32});
        vq.push_back('{"remu_big", 5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32});
        vq.push_back('{"div0",     5'd14, 32'd9,        32'd0,        32'hFFFFFFFF, 0});
        vq.push_back('{"rem0",     5'd16, 32'd9,        32'd0,        32'd9,        0});
        vq.push_back('{"divu0",    5'd15, 32'd9,        32'd0,        32'hFFFFFFFF, 0});
        vq.push_back('{"remu0",    5'd17, 32'd9,        32'd0,        32'd9,        0});
        vq.push_back('{"div_ovf",  5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
        vq.push_back('{"rem_ovf",  5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0});

        #12;
        chk("rst in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst busy",      {31'd0, bus.busy},      32'd0);
        chk("rst result",    bus.result,             32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            issue(vq[i].op, vq[i].a, vq[i].b, lat, res, acc);
            chk({vq[i].name, " accept"}, {31'd0, acc}, 32'd1);
            chk({vq[i].name, " latency"}, lat, vq[i].lat);
            chk({vq[i].name, " result"}, res, vq[i].exp);
            retire(vq[i].name);
        end

        // Backpressure: result must hold for 10 cycles with out_ready low.
        issue(5'd0, 32'd3, 32'd4, lat, res, acc);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== 32'd7 || bus.in_ready || !bus.busy) stable = 1'b0;
        end
        chk("bp stable", {31'd0, stable}, 32'd1);
        retire("bp");

        // Flush at N+10 of a multiply.
        issue(5'd10, 32'd3, 32'd5, lat, res, acc);
        chk("mul3x5", res, 32'd15);
        retire("mul3x5");
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 5'd10; bus.src1 = 32'd3; bus.src2 = 32'd5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush busy", {30'd0, bus.busy, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush no out_valid", {31'd0, seen}, 32'd0);
        issue(5'd0, 32'd1, 32'd1, lat, res, acc);
        chk("post flush add lat", lat, 0);
        chk("post flush add", res, 32'd2);
        retire("post flush");

        // Reset pulse at N+10 of a divide.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 5'd15; bus.src1 = 32'd100; bus.src2 = 32'd7;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("div busy mid", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst mid busy", {30'd0, bus.busy, bus.in_ready}, 32'd0);
        chk("rst mid result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst no out_valid", {31'd0, seen}, 32'd0);
        issue(5'd0, 32'd1, 32'd1, lat, res, acc);
        chk("post rst add lat", lat, 0);
        chk("post rst add", res, 32'd2);
        retire("post rst");

        // Flush wins over in_valid in the same cycle.
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 5'd0; bus.src1 = 32'd8; bus.src2 = 32'd8;
        #1 chk("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 chk("flush no accept", {30'd0, bus.busy, bus.out_valid}, 32'd0);
        bus.flush = 1'b0; bus.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/exu_mc.md
EXU_MC -- requirements
Module: exu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a power of two, at least 8.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  unit can accept an operation.
REQ-007 op  input  5  operation code (REQ-012).
REQ-008 src1, src2  input  XLEN  operands.
REQ-009 flush  input  1  abandon current operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result; result  output  XLEN; busy  output  1 (state != IDLE).

Function
REQ-012 op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; codes 18-31 SHALL yield result 0 as an ALU op.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE and flush low.
REQ-014 Accept = in_valid & in_ready at edge N; op, src1, src2 SHALL be captured at N; later input changes SHALL not affect the result.
REQ-015 ALU ops (0-9, 18-31): result registered at N; IDLE->DONE; out_valid=1 from cycle N+1.
REQ-016 Shifts SHALL use src2[SHW-1:0] only; SRA sign-extends; SLT signed, SLTU unsigned compare, result 1 or 0.
REQ-017 MUL ops: IDLE->MUL; iterative shift-add, one partial product per cycle, 2*XLEN-bit accumulator; XLEN iterations; MUL->DONE; out_valid from N+XLEN+1.
REQ-018 MUL returns low XLEN bits; MULH signed x signed, MULHSU signed src1 x unsigned src2, MULHU unsigned x unsigned return high XLEN bits.
REQ-019 DIV ops: IDLE->DIV; restoring division on magnitudes, one quotient bit per cycle, XLEN iterations; signs fixed at DIV->DONE; out_valid from N+XLEN+1; quotient truncates toward zero, remainder takes sign of src1.
REQ-020 Divide by zero SHALL bypass DIV state (IDLE->DONE, out_valid at N+1): DIV/DIVU result all ones, REM/REMU result src1.
REQ-021 Signed overflow (src1 = most-negative, src2 = all ones, DIV/REM) SHALL bypass: DIV result most-negative, REM result 0, out_valid at N+1.
REQ-022 Iteration counter SHALL be SHW+1 bits, cleared on accept, and SHALL not wrap within an operation.
REQ-023 In DONE, out_valid and result SHALL hold stable until out_ready=1; on that edge DONE->IDLE and out_valid drops next cycle; no accept in the same cycle (max throughput one op per 2 cycles).
REQ-024 flush=1 at any edge SHALL force IDLE, out_valid=0, counter cleared; pending result discarded; flush overrides in_valid and out_ready in the same cycle.
REQ-025 Arithmetic SHALL wrap modulo 2^XLEN; no exceptions or flags.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, out_valid 0, result 0, busy 0, counter 0, accumulators 0, independent of clk.
REQ-027 rst asserted mid-MUL/DIV SHALL abort the operation; first accept after rst deassertion SHALL behave as from power-up.
REQ-028 in_ready SHALL be 0 while rst=1.

Verification
REQ-029 XLEN=32: ADD 5,7 accepted at N -> out_valid at N+1, result 12; SRA 0x80000000, 0x24 -> 0xF8000000 (shift 4).
REQ-030 MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE at N+33; MULH same operands -> 0x00000000; MUL -> 0x00000001.
REQ-031 DIV -7,2 -> 0xFFFFFFFD, REM -7,2 -> 0xFFFFFFFF, both at N+33; DIVU 100,7 -> 14.
REQ-032 DIV 9,0 -> 0xFFFFFFFF and REM 9,0 -> 9 at N+1; DIV 0x80000000,0xFFFFFFFF -> 0x80000000, REM -> 0, at N+1.
REQ-033 Backpressure: out_ready held 0 for 10 cycles after out_valid -> result and out_valid stable, in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-034 flush at N+10 of MUL, and separately rst pulse at N+10 of DIV -> IDLE next cycle (rst: immediately), no out_valid; following ADD 1,1 -> 2 at its N+1.
